// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register for the pipelined RV32I core.
// Single-outstanding req/ack fetch with a one-entry skid buffer and redirect discard.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        stallD,
    input  logic        pcsrcE,
    input  logic [31:0] pctargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pcplus4D,
    output logic        validD
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;

    logic [31:0] target;
    logic [31:0] addr_plus4;

    // Redirect targets are always word aligned.
    assign target     = pctargetE & 32'hFFFF_FFFC;
    assign addr_plus4 = addr_q + 32'd4;

    assign imem_req  = RST_N && (state_q != HOLD);
    assign imem_addr = addr_q;

    assign instrD   = instr_q;
    assign pcD      = pc_q;
    assign pcplus4D = pcplus4_q;
    assign validD   = valid_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        redir_d   = redir_q;
        buf_d     = buf_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;

        case (state_q)
            FETCH: begin
                if (pcsrcE) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    if (imem_ack) begin
                        addr_d = target;
                    end else begin
                        redir_d = target;
                        state_d = DISCARD;
                    end
                end else if (imem_ack && !stallD) begin
                    instr_d   = imem_rdata;
                    pc_d      = addr_q;
                    pcplus4_d = addr_plus4;
                    valid_d   = 1'b1;
                    addr_d    = addr_plus4;
                end else if (imem_ack) begin
                    buf_d   = imem_rdata;
                    state_d = HOLD;
                end else if (!stallD) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (pcsrcE) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    addr_d  = target;
                    state_d = FETCH;
                end else if (!stallD) begin
                    instr_d   = buf_q;
                    pc_d      = addr_q;
                    pcplus4_d = addr_plus4;
                    valid_d   = 1'b1;
                    addr_d    = addr_plus4;
                    state_d   = FETCH;
                end
            end

            DISCARD: begin
                // The stale response must still be consumed before the new fetch.
                if (pcsrcE) begin
                    redir_d = target;
                end
                if (imem_ack) begin
                    addr_d  = pcsrcE ? target : redir_q;
                    state_d = FETCH;
                end
                if (!stallD) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= FETCH;
            addr_q    <= RESET_PC;
            redir_q   <= 32'd0;
            buf_q     <= 32'd0;
            instr_q   <= NOP_INSTR;
            pc_q      <= 32'd0;
            pcplus4_q <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            redir_q   <= redir_d;
            buf_q     <= buf_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect/latency traffic checked against a transaction-level model.
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] PATT = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        stallD;
    logic        pcsrcE;
    logic [31:0] pctargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcplus4D;
    logic        validD;

    always #5 CLK = ~CLK;

    fetch_stage dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .stallD     (stallD),
        .pcsrcE     (pcsrcE),
        .pctargetE  (pctargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instrD     (instrD),
        .pcD        (pcD),
        .pcplus4D   (pcplus4D),
        .validD     (validD)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ PATT;
    endfunction

    // Reference model: next fetch address, a queue of fetched-but-undelivered
    // instructions, and whether an abandoned request is still in flight.
    logic [31:0] m_addr;
    logic [31:0] m_pending_tgt;
    bit          m_stale;
    logic [31:0] m_skid[$];
    logic [31:0] m_instr, m_pc, m_pc4;
    bit          m_valid;

    // Memory: one request at a time, acks after a per-request wait count.
    int mem_cnt = 0;
    int mem_lat = 0;
    int lat_mode = 0;  // 0..3 fixed wait cycles, 4 = random per request

    task automatic model_reset();
        m_addr        = 32'd0;
        m_pending_tgt = 32'd0;
        m_stale       = 1'b0;
        m_skid.delete();
        m_instr       = NOP;
        m_pc          = 32'd0;
        m_pc4         = 32'd0;
        m_valid       = 1'b0;
        mem_cnt       = 0;
    endtask

    task automatic bubble();
        m_instr = NOP;
        m_valid = 1'b0;
    endtask

    task automatic deliver(input logic [31:0] w);
        m_instr = w;
        m_pc    = m_addr;
        m_pc4   = m_addr + 32'd4;
        m_valid = 1'b1;
        m_addr  = m_addr + 32'd4;
    endtask

    task automatic model_step(input bit st, input bit br, input logic [31:0] tg,
                              input bit ack, input logic [31:0] rd);
        logic [31:0] t;
        t = {tg[31:2], 2'b00};
        if (m_skid.size() != 0) begin
            if (br) begin
                m_skid.delete();
                bubble();
                m_addr = t;
            end else if (!st) begin
                deliver(m_skid.pop_front());
            end
        end else if (m_stale) begin
            if (br) m_pending_tgt = t;
            if (ack) begin
                m_stale = 1'b0;
                m_addr  = m_pending_tgt;
            end
            if (!st) bubble();
        end else begin
            if (br) begin
                bubble();
                if (ack) m_addr = t;
                else begin
                    m_stale       = 1'b1;
                    m_pending_tgt = t;
                end
            end else if (ack) begin
                if (!st) deliver(rd);
                else m_skid.push_back(rd);
            end else if (!st) begin
                bubble();
            end
        end
    endtask

    // One clock: drive inputs, check fetch-side outputs, advance model, check IF/ID.
    task automatic cycle(input bit st, input bit br, input logic [31:0] tg, input bit rn);
        bit          exp_req;
        bit          ack;
        logic [31:0] rd;
        stallD    = st;
        pcsrcE    = br;
        pctargetE = tg;
        RST_N     = rn;
        exp_req   = rn && (m_skid.size() == 0);
        ack       = 1'b0;
        if (!rn) begin
            mem_cnt = 0;
        end else if (exp_req) begin
            if (mem_cnt == 0) mem_lat = (lat_mode == 4) ? int'($urandom_range(0, 3)) : lat_mode;
            if (mem_cnt == mem_lat) begin
                ack     = 1'b1;
                mem_cnt = 0;
            end else begin
                mem_cnt++;
            end
        end
        rd         = ack ? mem_word(m_addr) : $urandom;
        imem_ack   = ack;
        imem_rdata = rd;
        #1;
        check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        check("imem_addr", imem_addr, m_addr);
        if (!rn) model_reset();
        else model_step(st, br, tg, ack, rd);
        @(posedge CLK);
        #1;
        check("validD", {31'd0, validD}, {31'd0, m_valid});
        check("instrD", instrD, m_instr);
        check("pcD", pcD, m_pc);
        check("pcplus4D", pcplus4D, m_pc4);
        if (validD === 1'b1) check("instr_vs_pc", instrD, mem_word(pcD));
    endtask

    initial begin
        int stall_pct, br_pct;
        RST_N      = 1'b0;
        stallD     = 1'b0;
        pcsrcE     = 1'b0;
        pctargetE  = 32'd0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();

        // Zero-wait memory: one instruction per cycle, then a stall on the 0x10 ack.
        lat_mode = 0;
        cycle(0, 0, 0, 0);
        check("rst_valid", {31'd0, validD}, 32'd0);
        check("rst_instr", instrD, NOP);
        repeat (4) cycle(0, 0, 0, 1);
        check("zw_pc", pcD, 32'h0C);
        check("zw_instr", instrD, 32'h0C ^ PATT);
        cycle(1, 0, 0, 1);
        check("st_hold_pc", pcD, 32'h0C);
        check("st_hold_req", {31'd0, imem_req}, 32'd0);
        repeat (2) cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("st_rel_pc", pcD, 32'h10);
        check("st_rel_instr", instrD, 32'h10 ^ PATT);
        check("st_rel_addr", imem_addr, 32'h14);
        check("st_rel_valid", {31'd0, validD}, 32'd1);

        // Two wait cycles, then redirect while the 0x20 request is outstanding.
        lat_mode = 2;
        cycle(0, 0, 0, 0);
        repeat (9) cycle(0, 0, 0, 1);
        check("w2_pc", pcD, 32'h08);
        for (int i = 0; i < 40 && m_addr != 32'h20; i++) cycle(0, 0, 0, 1);
        check("w2_reach20", imem_addr, 32'h20);
        cycle(0, 1, 32'h103, 1);
        check("rd_valid", {31'd0, validD}, 32'd0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("rd_addr", imem_addr, 32'h100);
        check("rd_drop", {31'd0, validD}, 32'd0);
        repeat (3) cycle(0, 0, 0, 1);
        check("rd_first_pc", pcD, 32'h100);
        check("rd_first_instr", instrD, 32'h100 ^ PATT);

        // Redirect coincident with ack and stall, wraparound, then reset mid-stream.
        lat_mode = 0;
        repeat (2) cycle(0, 0, 0, 1);
        cycle(1, 1, 32'h200, 1);
        check("brst_valid", {31'd0, validD}, 32'd0);
        check("brst_instr", instrD, NOP);
        check("brst_addr", imem_addr, 32'h200);
        check("brst_req", {31'd0, imem_req}, 32'd1);
        cycle(0, 1, 32'hFFFF_FFFF, 1);
        cycle(0, 0, 0, 1);
        check("wrap_pc", pcD, 32'hFFFF_FFFC);
        check("wrap_pc4", pcplus4D, 32'd0);
        check("wrap_addr", imem_addr, 32'd0);
        cycle(0, 1, 32'h40, 1);
        cycle(1, 0, 0, 0);
        check("mrst_valid", {31'd0, validD}, 32'd0);
        check("mrst_instr", instrD, NOP);
        check("mrst_pc", pcD, 32'd0);
        check("mrst_addr", imem_addr, 32'd0);

        // Randomized traffic with varying stall/redirect density and latency.
        for (int ph = 0; ph < 4; ph++) begin
            lat_mode  = (ph == 0) ? 0 : 4;
            stall_pct = 10 + ph * 15;
            br_pct    = 3 + ph * 4;
            for (int c = 0; c < 400; c++) begin
                cycle(($urandom_range(0, 99) < stall_pct),
                      ($urandom_range(0, 99) < br_pct),
                      $urandom,
                      !($urandom_range(0, 199) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
